// File: rtl/eai_req_master_pkg.sv
// rtl/eai_req_master_pkg.sv - shared EAI widths, command struct and issue FSM states
package eai_req_master_pkg;

  localparam int EAI_DATA_W = 32;
  localparam int EAI_ITAG_W = 2;
  localparam int EAI_CMD_W  = 3 * EAI_DATA_W;

  typedef logic [EAI_DATA_W-1:0] eai_data_t;
  typedef logic [EAI_ITAG_W-1:0] eai_itag_t;

  // One queued coprocessor command; instr sits in the top bits.
  typedef struct packed {
    eai_data_t instr;
    eai_data_t rs1;
    eai_data_t rs2;
  } eai_cmd_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } eai_state_t;

  // Tags are 2 bits and wrap naturally 3 -> 0.
  function automatic eai_itag_t itag_next(input eai_itag_t t);
    return t + eai_itag_t'(1);
  endfunction

endpackage

// File: rtl/eai_req_master_if.sv
// rtl/eai_req_master_if.sv - EAI request/response channel bundle
interface eai_req_master_if;
  import eai_req_master_pkg::*;

  logic      eai_req_valid;
  logic      eai_req_ready;
  eai_data_t eai_req_instr;
  eai_data_t eai_req_rs1;
  eai_data_t eai_req_rs2;
  eai_itag_t eai_req_itag;

  logic      eai_rsp_valid;
  logic      eai_rsp_ready;
  eai_data_t eai_rsp_wdat;
  eai_itag_t eai_rsp_itag;
  logic      eai_rsp_err;

  logic      eai_mem_holdup;

  modport master (
    output eai_req_valid, eai_req_instr, eai_req_rs1, eai_req_rs2, eai_req_itag,
    output eai_rsp_ready,
    input  eai_req_ready,
    input  eai_rsp_valid, eai_rsp_wdat, eai_rsp_itag, eai_rsp_err,
    input  eai_mem_holdup
  );

  modport slave (
    input  eai_req_valid, eai_req_instr, eai_req_rs1, eai_req_rs2, eai_req_itag,
    input  eai_rsp_ready,
    output eai_req_ready,
    output eai_rsp_valid, eai_rsp_wdat, eai_rsp_itag, eai_rsp_err,
    output eai_mem_holdup
  );

endinterface

// File: rtl/eai_cmd_fifo.sv
// rtl/eai_cmd_fifo.sv - register-based command FIFO, power-of-two depth (>= 2)
module eai_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // full is taken from the current state, so a push while full is refused
  // even if the head is popped on the same edge.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer advance; reset empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are don't-care until pointed at by a valid entry.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/eai_req_master.sv
// rtl/eai_req_master.sv - queues host commands and issues them as tagged EAI requests
module eai_req_master
  import eai_req_master_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  send_instr,
  input  logic [31:0]           instr,
  input  logic [31:0]           rs1_data,
  input  logic [31:0]           rs2_data,
  output logic                  cmd_full,
  eai_req_master_if.master      eai,
  output logic                  rsp_vld,
  output logic [31:0]           rsp_wdat,
  output logic [1:0]            rsp_itag,
  output logic                  rsp_err,
  output logic [15:0]           retire_cnt,
  output logic [2:0]            outst_cnt,
  output logic                  idle,
  output logic                  ovf_err,
  output logic                  tag_err
);

  localparam logic [2:0] MAX_OUTST_C = 3'(MAX_OUTST);

  eai_state_t state;
  eai_state_t state_nxt;
  eai_cmd_t   push_cmd;
  eai_cmd_t   head_cmd;
  eai_cmd_t   req_cmd;
  eai_itag_t  issue_tag;
  eai_itag_t  exp_tag;
  logic       fifo_full;
  logic       fifo_empty;
  logic       req_valid;
  logic       load_req;
  logic       req_hs;
  logic       rsp_hs;
  logic       can_issue;

  assign push_cmd = '{instr: instr, rs1: rs1_data, rs2: rs2_data};

  eai_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (EAI_CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (send_instr),
    .wdata (push_cmd),
    .pop   (req_hs),
    .rdata (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign req_hs    = req_valid & eai.eai_req_ready;
  assign rsp_hs    = eai.eai_rsp_valid & eai.eai_rsp_ready;
  assign can_issue = ~fifo_empty && (outst_cnt < MAX_OUTST_C) && ~eai.eai_mem_holdup;

  // Issue FSM next state; payload is latched on the IDLE->REQ move so it stays put while waiting.
  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    load_req  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (can_issue) begin
          state_nxt = ST_REQ;
          load_req  = 1'b1;
        end
      end
      ST_REQ: begin
        req_valid = 1'b1;
        if (eai.eai_req_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Issue FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Request payload register, captured from the FIFO head when a request is launched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        req_cmd <= '0;
    else if (load_req) req_cmd <= head_cmd;
  end

  // Tag tracking, outstanding count, retire count and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_tag  <= '0;
      exp_tag    <= '0;
      outst_cnt  <= '0;
      retire_cnt <= '0;
      ovf_err    <= 1'b0;
      tag_err    <= 1'b0;
    end else begin
      if (req_hs) issue_tag <= itag_next(issue_tag);
      if (rsp_hs) begin
        exp_tag    <= itag_next(exp_tag);
        retire_cnt <= retire_cnt + 16'd1;
        if (eai.eai_rsp_itag != exp_tag) tag_err <= 1'b1;
      end
      case ({req_hs, rsp_hs})
        2'b10:   outst_cnt <= outst_cnt + 3'd1;
        2'b01:   outst_cnt <= outst_cnt - 3'd1;
        default: outst_cnt <= outst_cnt;
      endcase
      if (send_instr && fifo_full) ovf_err <= 1'b1;
    end
  end

  // Registered echo of each accepted response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld  <= 1'b0;
      rsp_wdat <= '0;
      rsp_itag <= '0;
      rsp_err  <= 1'b0;
    end else begin
      rsp_vld <= rsp_hs;
      if (rsp_hs) begin
        rsp_wdat <= eai.eai_rsp_wdat;
        rsp_itag <= eai.eai_rsp_itag;
        rsp_err  <= eai.eai_rsp_err;
      end
    end
  end

  assign eai.eai_req_valid = req_valid;
  assign eai.eai_req_instr = req_cmd.instr;
  assign eai.eai_req_rs1   = req_cmd.rs1;
  assign eai.eai_req_rs2   = req_cmd.rs2;
  assign eai.eai_req_itag  = issue_tag;
  assign eai.eai_rsp_ready = (outst_cnt != 3'd0);

  assign cmd_full = fifo_full;
  assign idle     = fifo_empty && (outst_cnt == 3'd0) && (state == ST_IDLE);

endmodule

// File: tb/tb_eai_req_master.sv
// tb/tb_eai_req_master.sv - directed self-checking bench for eai_req_master
module tb_eai_req_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        send_instr = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        cmd_full;
  logic        rsp_vld;
  logic [31:0] rsp_wdat;
  logic [1:0]  rsp_itag;
  logic        rsp_err;
  logic [15:0] retire_cnt;
  logic [2:0]  outst_cnt;
  logic        idle;
  logic        ovf_err;
  logic        tag_err;

  int total = 0;
  int bad   = 0;

  eai_req_master_if eif();

  eai_req_master #(.CMD_DEPTH(4), .MAX_OUTST(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .send_instr (send_instr),
    .instr      (instr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .cmd_full   (cmd_full),
    .eai        (eif),
    .rsp_vld    (rsp_vld),
    .rsp_wdat   (rsp_wdat),
    .rsp_itag   (rsp_itag),
    .rsp_err    (rsp_err),
    .retire_cnt (retire_cnt),
    .outst_cnt  (outst_cnt),
    .idle       (idle),
    .ovf_err    (ovf_err),
    .tag_err    (tag_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    send_instr         = 1'b0;
    eif.eai_req_ready  = 1'b0;
    eif.eai_rsp_valid  = 1'b0;
    eif.eai_rsp_wdat   = '0;
    eif.eai_rsp_itag   = '0;
    eif.eai_rsp_err    = 1'b0;
    eif.eai_mem_holdup = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
    send_instr = 1'b1;
    instr      = i;
    rs1_data   = r1;
    rs2_data   = r2;
    step();
    send_instr = 1'b0;
  endtask

  task automatic send_rsp(input logic [31:0] wdat, input logic [1:0] itag, input logic err);
    eif.eai_rsp_valid = 1'b1;
    eif.eai_rsp_wdat  = wdat;
    eif.eai_rsp_itag  = itag;
    eif.eai_rsp_err   = err;
    step();
    eif.eai_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({eif.eai_req_valid, eif.eai_rsp_ready, rsp_vld, ovf_err, tag_err, cmd_full, idle} !== 7'b0000001) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000001", {eif.eai_req_valid, eif.eai_rsp_ready, rsp_vld, ovf_err, tag_err, cmd_full, idle});
    end
    total++;
    if ({eif.eai_req_instr, eif.eai_req_rs1, eif.eai_req_rs2, eif.eai_req_itag, rsp_wdat, rsp_itag, rsp_err} !== '0) begin
      bad++;
      $display("FAIL reset_data: req_instr=%h rs1=%h rs2=%h itag=%h rsp_wdat=%h want all 0",
               eif.eai_req_instr, eif.eai_req_rs1, eif.eai_req_rs2, eif.eai_req_itag, rsp_wdat);
    end
    total++;
    if ({retire_cnt, outst_cnt} !== 19'd0) begin
      bad++;
      $display("FAIL reset_counts: retire=%0d outst=%0d want 0 0", retire_cnt, outst_cnt);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    do_reset();
    eif.eai_req_ready = 1'b1;
    push(32'h0000_200B, 32'd5, 32'd7);
    total++;
    if (eif.eai_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_valid_early: got %b want 0", eif.eai_req_valid);
    end
    step();
    total++;
    if ({eif.eai_req_valid, eif.eai_req_itag, eif.eai_req_instr, eif.eai_req_rs1, eif.eai_req_rs2} !==
        {1'b1, 2'd0, 32'h0000_200B, 32'd5, 32'd7}) begin
      bad++;
      $display("FAIL single_req: valid=%b itag=%0d instr=%h rs1=%h rs2=%h want 1 0 0000200b 5 7",
               eif.eai_req_valid, eif.eai_req_itag, eif.eai_req_instr, eif.eai_req_rs1, eif.eai_req_rs2);
    end
    step();
    total++;
    if ({eif.eai_req_valid, outst_cnt, eif.eai_rsp_ready} !== {1'b0, 3'd1, 1'b1}) begin
      bad++;
      $display("FAIL single_after_hs: valid=%b outst=%0d rsp_ready=%b want 0 1 1", eif.eai_req_valid, outst_cnt, eif.eai_rsp_ready);
    end
    send_rsp(32'hC, 2'd0, 1'b0);
    total++;
    if ({rsp_vld, rsp_wdat, rsp_itag, rsp_err, retire_cnt, outst_cnt, idle, tag_err} !==
        {1'b1, 32'hC, 2'd0, 1'b0, 16'd1, 3'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL single_rsp: vld=%b wdat=%h itag=%0d retire=%0d outst=%0d idle=%b tag_err=%b want 1 c 0 1 0 1 0",
               rsp_vld, rsp_wdat, rsp_itag, retire_cnt, outst_cnt, idle, tag_err);
    end
    step();
    total++;
    if (rsp_vld !== 1'b0) begin
      bad++;
      $display("FAIL single_rsp_pulse: got %b want 0", rsp_vld);
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(32'h100 + i, i, i + 16);
      if (i == 2) begin
        total++;
        if (cmd_full !== 1'b0) begin
          bad++;
          $display("FAIL bp_not_full_at3: got %b want 0", cmd_full);
        end
      end
    end
    total++;
    if ({cmd_full, ovf_err} !== 2'b10) begin
      bad++;
      $display("FAIL bp_full_at4: full=%b ovf=%b want 1 0", cmd_full, ovf_err);
    end
    push(32'h1FF, 0, 0);
    total++;
    if (ovf_err !== 1'b1) begin
      bad++;
      $display("FAIL bp_ovf: got %b want 1", ovf_err);
    end
    eif.eai_req_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (eif.eai_req_valid) begin
        total++;
        if ({eif.eai_req_itag, eif.eai_req_instr} !== {n[1:0], 32'h100 + n}) begin
          bad++;
          $display("FAIL bp_req%0d: itag=%0d instr=%h want %0d %h", n, eif.eai_req_itag, eif.eai_req_instr, n[1:0], 32'h100 + n);
        end
        n++;
      end
      step();
    end
    total++;
    if ({n, outst_cnt} !== {32'd4, 3'd4}) begin
      bad++;
      $display("FAIL bp_count: requests=%0d outst=%0d want 4 4", n, outst_cnt);
    end
  endtask

  task automatic test_outstanding();
    int  seen;
    int  got;
    seen = 0;
    push(32'h300, 3, 3);
    for (int c = 0; c < 6; c++) begin
      if (eif.eai_req_valid) seen = 1;
      step();
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL outst_limit: request seen=%0d want 0", seen);
    end
    send_rsp(32'h55, 2'd0, 1'b0);
    total++;
    if (outst_cnt !== 3'd3) begin
      bad++;
      $display("FAIL outst_dec: got %0d want 3", outst_cnt);
    end
    got = 0;
    for (int c = 0; c < 5; c++) begin
      if (got == 0 && eif.eai_req_valid) begin
        got = 1;
        total++;
        if ({eif.eai_req_itag, eif.eai_req_instr} !== {2'd0, 32'h300}) begin
          bad++;
          $display("FAIL outst_wrap_req: itag=%0d instr=%h want 0 300", eif.eai_req_itag, eif.eai_req_instr);
        end
      end
      step();
    end
    total++;
    if ({got, outst_cnt} !== {32'd1, 3'd4}) begin
      bad++;
      $display("FAIL outst_fifth: issued=%0d outst=%0d want 1 4", got, outst_cnt);
    end
  endtask

  task automatic test_holdup();
    int seen;
    int stable;
    do_reset();
    eif.eai_mem_holdup = 1'b1;
    push(32'h400, 32'd1, 32'd2);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (eif.eai_req_valid) seen = 1;
      step();
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL holdup_block: request seen=%0d want 0", seen);
    end
    eif.eai_mem_holdup = 1'b0;
    step();
    total++;
    if ({eif.eai_req_valid, eif.eai_req_instr} !== {1'b1, 32'h400}) begin
      bad++;
      $display("FAIL holdup_release: valid=%b instr=%h want 1 400", eif.eai_req_valid, eif.eai_req_instr);
    end
    eif.eai_mem_holdup = 1'b1;
    stable = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (eif.eai_req_valid !== 1'b1 || eif.eai_req_instr !== 32'h400 || eif.eai_req_rs2 !== 32'd2) stable = 0;
    end
    total++;
    if (stable !== 1) begin
      bad++;
      $display("FAIL holdup_hold: stable=%0d want 1", stable);
    end
    eif.eai_req_ready = 1'b1;
    step();
    total++;
    if ({eif.eai_req_valid, outst_cnt} !== {1'b0, 3'd1}) begin
      bad++;
      $display("FAIL holdup_hs: valid=%b outst=%0d want 0 1", eif.eai_req_valid, outst_cnt);
    end
    eif.eai_mem_holdup = 1'b0;
    eif.eai_req_ready  = 1'b0;
  endtask

  task automatic test_tag();
    do_reset();
    eif.eai_req_ready = 1'b1;
    push(32'h500, 0, 0);
    step();
    step();
    send_rsp(32'hAA, 2'd2, 1'b1);
    total++;
    if ({tag_err, outst_cnt, rsp_itag, rsp_err} !== {1'b1, 3'd0, 2'd2, 1'b1}) begin
      bad++;
      $display("FAIL tag_mismatch: tag_err=%b outst=%0d rsp_itag=%0d rsp_err=%b want 1 0 2 1", tag_err, outst_cnt, rsp_itag, rsp_err);
    end
    push(32'h501, 0, 0);
    step();
    step();
    push(32'h502, 0, 0);
    step();
    total++;
    if ({eif.eai_req_valid, eif.eai_req_itag, outst_cnt} !== {1'b1, 2'd2, 3'd1}) begin
      bad++;
      $display("FAIL tag_pre_both: valid=%b itag=%0d outst=%0d want 1 2 1", eif.eai_req_valid, eif.eai_req_itag, outst_cnt);
    end
    send_rsp(32'hBB, 2'd1, 1'b0);
    total++;
    if ({eif.eai_req_valid, outst_cnt, retire_cnt, rsp_itag, tag_err} !== {1'b0, 3'd1, 16'd2, 2'd1, 1'b1}) begin
      bad++;
      $display("FAIL tag_both_hs: valid=%b outst=%0d retire=%0d rsp_itag=%0d tag_err=%b want 0 1 2 1 1",
               eif.eai_req_valid, outst_cnt, retire_cnt, rsp_itag, tag_err);
    end
  endtask

  task automatic test_full_pop();
    int n;
    int order_ok;
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h600 + i, 0, 0);
    total++;
    if ({cmd_full, eif.eai_req_valid, ovf_err} !== 3'b110) begin
      bad++;
      $display("FAIL fp_setup: full=%b valid=%b ovf=%b want 1 1 0", cmd_full, eif.eai_req_valid, ovf_err);
    end
    eif.eai_req_ready = 1'b1;
    push(32'h6FF, 0, 0);
    total++;
    if ({ovf_err, cmd_full} !== 2'b10) begin
      bad++;
      $display("FAIL fp_push_rejected: ovf=%b full=%b want 1 0", ovf_err, cmd_full);
    end
    n = 0;
    order_ok = 1;
    for (int c = 0; c < 20; c++) begin
      if (eif.eai_req_valid) begin
        if (eif.eai_req_instr !== 32'h601 + n) order_ok = 0;
        n++;
      end
      step();
    end
    total++;
    if ({n, order_ok} !== {32'd3, 32'd1}) begin
      bad++;
      $display("FAIL fp_drain: requests=%0d in_order=%0d want 3 1", n, order_ok);
    end
  endtask

  task automatic test_reset_mid();
    int reached;
    int echoed;
    do_reset();
    eif.eai_req_ready = 1'b1;
    push(32'h700, 0, 0);
    push(32'h701, 0, 0);
    reached = 0;
    for (int c = 0; c < 10; c++) begin
      if (outst_cnt == 3'd2) reached = 1;
      if (reached == 0) step();
    end
    total++;
    if (reached !== 1) begin
      bad++;
      $display("FAIL rm_two_outst: reached=%0d outst=%0d want 1 2", reached, outst_cnt);
    end
    eif.eai_req_ready = 1'b0;
    push(32'h702, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({eif.eai_req_valid, eif.eai_rsp_ready, rsp_vld, cmd_full, idle, outst_cnt, eif.eai_req_itag, eif.eai_req_instr} !==
        {5'b00001, 3'd0, 2'd0, 32'd0}) begin
      bad++;
      $display("FAIL rm_async: valid=%b rsp_ready=%b rsp_vld=%b full=%b idle=%b outst=%0d itag=%0d instr=%h want 0 0 0 0 1 0 0 0",
               eif.eai_req_valid, eif.eai_rsp_ready, rsp_vld, cmd_full, idle, outst_cnt, eif.eai_req_itag, eif.eai_req_instr);
    end
    step();
    rst_n = 1'b1;
    eif.eai_rsp_valid = 1'b1;
    eif.eai_rsp_itag  = 2'd0;
    eif.eai_rsp_wdat  = 32'h77;
    echoed = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (rsp_vld !== 1'b0 || eif.eai_rsp_ready !== 1'b0) echoed = 1;
    end
    eif.eai_rsp_valid = 1'b0;
    total++;
    if ({echoed, retire_cnt, tag_err, idle} !== {32'd0, 16'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL rm_rsp_ignored: echoed=%0d retire=%0d tag_err=%b idle=%b want 0 0 0 1", echoed, retire_cnt, tag_err, idle);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_outstanding();
    test_holdup();
    test_tag();
    test_full_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/eai_req_master.md
EAI_REQ_MASTER -- requirements
Module: eai_req_master

Interface
REQ-001 Parameter CMD_DEPTH, default 4: command FIFO entries, power of two.
REQ-002 Parameter MAX_OUTST, default 4: maximum outstanding EAI requests, at most 4 because itag is 2 bits.
REQ-003 clk  in  1: single clock, rising edge.
REQ-004 rst_n  in  1: asynchronous active-low reset.
REQ-005 send_instr  in  1: host push strobe, sampled at posedge.
REQ-006 instr, rs1_data, rs2_data  in  32 each: command word captured with send_instr.
REQ-007 cmd_full  out  1: FIFO holds CMD_DEPTH entries.
REQ-008 eai_req_valid  out  1; eai_req_ready  in  1: request handshake.
REQ-009 eai_req_instr, eai_req_rs1, eai_req_rs2  out  32 each; eai_req_itag  out  2.
REQ-010 eai_rsp_valid  in  1; eai_rsp_ready  out  1: response handshake.
REQ-011 eai_rsp_wdat  in  32; eai_rsp_itag  in  2; eai_rsp_err  in  1.
REQ-012 eai_mem_holdup  in  1: blocks new request issue.
REQ-013 rsp_vld  out  1; rsp_wdat  out  32; rsp_itag  out  2; rsp_err  out  1: registered response echo.
REQ-014 retire_cnt  out  16; outst_cnt  out  3; idle  out  1; ovf_err  out  1; tag_err  out  1.

Function
REQ-015 Push: send_instr=1 with cmd_full=0 writes {instr,rs1_data,rs2_data} at the FIFO tail; the entry is visible at the FIFO head on the next cycle.
REQ-016 Push with cmd_full=1 drops the command, leaves FIFO contents unchanged, and sets sticky ovf_err.
REQ-017 The issue FSM has two states. IDLE -> REQ when FIFO is non-empty, outst_cnt<MAX_OUTST and eai_mem_holdup=0. REQ -> IDLE on eai_req_valid&eai_req_ready.
REQ-018 eai_req_valid=1 exactly in state REQ. While in REQ, eai_req_* SHALL hold stable until the handshake, regardless of eai_mem_holdup.
REQ-019 The earliest request issue is 2 cycles after the push edge, giving one request per 2 cycles maximum throughput.
REQ-020 On request handshake: pop the FIFO head, increment the 2-bit issue tag with wrap 3->0, and increment outst_cnt.
REQ-021 eai_req_itag carries the issue tag; after reset the first request uses itag 0.
REQ-022 eai_rsp_ready = (outst_cnt != 0), driven from registered state.
REQ-023 On response handshake: decrement outst_cnt; compare eai_rsp_itag with the expected tag (2-bit, wraps); on mismatch set sticky tag_err. The expected tag increments regardless of match.
REQ-024 A request handshake and a response handshake in the same cycle leave outst_cnt unchanged; both tags still advance.
REQ-025 rsp_vld pulses 1 cycle after each response handshake, with rsp_wdat, rsp_itag and rsp_err registered from that handshake.
REQ-026 retire_cnt increments on each response handshake and wraps 0xFFFF->0.
REQ-027 idle = FIFO empty & outst_cnt==0 & state IDLE.
REQ-028 A push and a pop in the same cycle on a full FIFO: the push is rejected because cmd_full is evaluated before the pop.
REQ-029 The ICB memory channel is out of scope for this block; this block does not drive eai_icb_*.

Reset
REQ-030 With rst_n=0, asynchronously: FIFO empty, FSM IDLE, tags 0, outst_cnt 0, retire_cnt 0.
REQ-031 Reset values of outputs: eai_req_valid 0, eai_rsp_ready 0, rsp_vld 0, ovf_err 0, tag_err 0, cmd_full 0, idle 1, eai_req_*/rsp_* data 0.
REQ-032 Reset mid-operation discards queued and outstanding commands; no response is echoed after deassertion.

Structure
REQ-033 The shared package holds the EAI field widths (32-bit data, 2-bit itag), the packed command struct {instr,rs1,rs2} of 96 bits, and the FSM state enum.
REQ-034 The FIFO is one sub-module, eai_cmd_fifo (parameterised depth and width, registered storage, full/empty flags).

Verification
REQ-035 Single command: push instr=0x0000_200B, rs1=5, rs2=7, with eai_req_ready=1 -> valid high 2 cycles after the push, itag=0, one handshake. Then rsp wdat=0xC with itag 0 -> rsp_vld pulse, rsp_wdat=0xC, retire_cnt=1, idle=1.
REQ-036 Back-pressure: push 5 commands while eai_req_ready=0 -> cmd_full after the 4th push, ovf_err=1 after the 5th. Release ready -> exactly 4 requests with itags 0,1,2,3.
REQ-037 Outstanding limit: 4 requests accepted and no response -> outst_cnt=4, no 5th request. One response -> 5th request issued with itag 0 (wrap).
REQ-038 Holdup: eai_mem_holdup=1 before issue -> valid stays 0. Holdup asserted while valid=1 -> valid and payload held until ready.
REQ-039 Tag mismatch: response with itag 2 when 0 is expected -> tag_err=1, outst_cnt still decrements. Simultaneous request and response handshakes -> outst_cnt unchanged.
REQ-040 Async reset with 2 requests outstanding -> all outputs at reset values immediately; later responses ignored while eai_rsp_ready=0.
